trace_buffer: RTL
=================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CAPTURE_LEN, default 64, retired records accepted per trigger, range 1..65535.
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port arm, input, 1, single-cycle request to arm the trigger.
REQ-006 Port clear, input, 1, single-cycle FIFO flush.
REQ-007 Port trig_pc, input, 32, PC value that starts capture.
REQ-008 Port retire_valid, input, 1, one instruction retires this cycle.
REQ-009 Ports reg_write (1), pc (32), instr (32), reg_waddr (5), reg_wdata (32), inputs, retire record from the core debug outputs.
REQ-010 Ports out_valid (output, 1) and out_ready (input, 1), drain handshake.
REQ-011 Ports out_we (1), out_pc (32), out_instr (32), out_waddr (5), out_wdata (32), outputs, head record.
REQ-012 Port state, output, 2, FSM state code.
REQ-013 Port count, output, $clog2(DEPTH)+1, entries held.
REQ-014 Port drop_count, output, 16, records lost to a full FIFO; overflow, output, 1, sticky loss flag.

Function
REQ-015 FSM states IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-016 arm=1 in any state SHALL enter ARMED next cycle and zero the capture counter, drop_count and overflow; FIFO contents are kept.
REQ-017 ARMED -> CAPTURE when retire_valid=1 and pc==trig_pc; the triggering record SHALL itself be offered for push.
REQ-018 In CAPTURE every retire_valid=1 cycle offers one record and increments the capture counter, whether pushed or dropped.
REQ-019 CAPTURE -> DONE on the cycle the capture counter reaches CAPTURE_LEN; no record is offered in DONE or IDLE.
REQ-020 arm has priority over the trigger match and over the CAPTURE -> DONE transition in the same cycle.
REQ-021 Push SHALL succeed when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-022 A record offered and not pushed SHALL increment drop_count (saturating at 0xFFFF) and set overflow.
REQ-023 out_valid = (count!=0); pop occurs when out_valid && out_ready; head fields are driven directly from storage.
REQ-024 A record pushed at edge N SHALL be visible at the outputs in cycle N+1 if the FIFO was empty.
REQ-025 A simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.
REQ-026 clear=1 SHALL empty the FIFO next cycle (count=0, out_valid=0) and discard any same-cycle push or pop; FSM and counters are unaffected.
REQ-027 Output fields SHALL be don't-care while out_valid=0 and SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst low SHALL immediately force state=IDLE, count=0, out_valid=0, drop_count=0, overflow=0, capture counter=0, pointers=0, timestamp=0.
REQ-029 Storage array is not reset.
REQ-030 Reset asserted mid-capture SHALL discard all buffered records.

Configuration
REQ-031 Macro TRACE_BUFFER_TIMESTAMP_EN: when defined, a free-running 32-bit cycle counter (reset 0, wraps) is stored with each record and presented on an added 32-bit output out_ts.
REQ-032 Without the macro, out_ts and the counter SHALL be absent and all other behaviour is identical.

Structure
REQ-033 Shared package trace_pkg SHALL hold the state enum, the trace_rec_t packed struct (we, pc, instr, waddr, wdata[, ts]) and the drop_count width constant.
REQ-034 The FIFO SHALL be a sub-module trace_fifo (storage, pointers, count); the FSM and counters live in trace_buffer.

Verification
REQ-035 Reset, arm, trig_pc=0x10; retire pc 0x0,0x4,…,0x10,0x14 -> FIFO holds exactly records 0x10 and 0x14 in order; state=CAPTURE.
REQ-036 CAPTURE_LEN=4, out_ready=1, trigger then 6 retires -> 4 records drained, state=DONE, drop_count=0.
REQ-037 DEPTH=16, out_ready=0, trigger then 20 retires -> count=16, drop_count=4, overflow=1, head pc=trig_pc.
REQ-038 FIFO full, same-cycle push and pop -> count stays 16, new record at tail, drop_count unchanged.
REQ-039 Four records held, clear and out_ready=1 pulsed together -> count=0 next cycle, no pop side effect, state unchanged.
REQ-040 rst low during CAPTURE with 5 records held -> immediately state=IDLE, count=0, out_valid=0; with TRACE_BUFFER_TIMESTAMP_EN the first post-reset record has ts equal to the cycle count since reset release.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the retire-trace buffer.
//   state_t      - capture FSM state codes (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
//   trace_rec_t  - one retired-instruction record as stored in the FIFO
//   DROP_W       - width of the saturating drop counter
//   CAPT_W       - width of the per-trigger capture counter
// Optional macro TRACE_BUFFER_TIMESTAMP_EN adds a 32-bit ts field to each record.
package trace_pkg;

  localparam int DROP_W = 16;
  localparam int CAPT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH-entry record FIFO (power-of-two DEPTH, minimum 2).
//   clk, rst      - clock, asynchronous active-low reset (pointers/count only)
//   clear         - flush; overrides any same-cycle push or pop
//   push, wr_rec  - offered record
//   pop_req       - consumer ready; a pop happens only when not empty
//   push_acc      - the offered record fits (space, or a pop frees a slot)
//   rd_rec, count - head record (straight from storage) and occupancy
import trace_pkg::*;

module trace_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  trace_rec_t             wr_rec,
  input  logic                   pop_req,
  output logic                   push_acc,
  output trace_rec_t             rd_rec,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  trace_rec_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          do_push;
  logic          do_pop;

  // Acceptance ignores clear: a flushed record is discarded, not dropped.
  assign pop      = pop_req && (count != '0);
  assign push_acc = push && ((count != FULL_CNT) || pop);
  assign do_push  = push_acc && !clear;
  assign do_pop   = pop && !clear;
  assign rd_rec   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_rec;
  end

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: triggered retire-trace capture into a drainable FIFO.
//   clk, rst          - clock, asynchronous active-low reset
//   arm, clear        - arm trigger (clears counters) / flush FIFO
//   trig_pc           - PC whose retirement starts a capture
//   retire_valid, reg_write, pc, instr, reg_waddr, reg_wdata - retire record in
//   out_valid/out_ready, out_we, out_pc, out_instr, out_waddr, out_wdata - head out
//   out_ts            - head timestamp (only with TRACE_BUFFER_TIMESTAMP_EN)
//   state, count, drop_count, overflow - status
// Macro TRACE_BUFFER_TIMESTAMP_EN: adds a free-running cycle counter stored
// with every record and presented on out_ts.
import trace_pkg::*;

module trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int CAPTURE_LEN = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   clear,
  input  logic [31:0]            trig_pc,
  input  logic                   retire_valid,
  input  logic                   reg_write,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic [4:0]             reg_waddr,
  input  logic [31:0]            reg_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_we,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [4:0]             out_waddr,
  output logic [31:0]            out_wdata,
`ifdef TRACE_BUFFER_TIMESTAMP_EN
  output logic [31:0]            out_ts,
`endif
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   overflow
);

  localparam logic [CAPT_W-1:0] CAP_LAST = CAPT_W'(CAPTURE_LEN);

  state_t             st_q;
  logic [CAPT_W-1:0]  cap_cnt;
  logic [CAPT_W-1:0]  cap_nxt;
  logic               offer;
  logic               push_acc;
  trace_rec_t         wr_rec;
  trace_rec_t         rd_rec;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The trigger record itself is offered; arm suppresses any offer that cycle.
  assign offer   = retire_valid && !arm &&
                   ((st_q == ST_CAPTURE) || ((st_q == ST_ARMED) && (pc == trig_pc)));
  assign cap_nxt = cap_cnt + 1'b1;

`ifdef TRACE_BUFFER_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 1'b1;
  end
`endif

  always_comb begin
    wr_rec       = '0;
    wr_rec.we    = reg_write;
    wr_rec.pc    = pc;
    wr_rec.instr = instr;
    wr_rec.waddr = reg_waddr;
    wr_rec.wdata = reg_wdata;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    wr_rec.ts    = ts_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= ST_IDLE;
      cap_cnt    <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (arm) begin
      st_q       <= ST_ARMED;
      cap_cnt    <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (offer) begin
      cap_cnt <= cap_nxt;
      if (cap_nxt == CAP_LAST) st_q <= ST_DONE;
      else                     st_q <= ST_CAPTURE;
      if (!push_acc) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (offer),
    .wr_rec   (wr_rec),
    .pop_req  (out_ready),
    .push_acc (push_acc),
    .rd_rec   (rd_rec),
    .count    (count)
  );

  assign state     = st_q;
  assign out_valid = (count != '0);
  assign out_we    = rd_rec.we;
  assign out_pc    = rd_rec.pc;
  assign out_instr = rd_rec.instr;
  assign out_waddr = rd_rec.waddr;
  assign out_wdata = rd_rec.wdata;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
  assign out_ts    = rd_rec.ts;
`endif

endmodule
